core_lsu: RTL

- Parametrised load/store unit for the core's M stage.
- Replaces the blocking single-access memory stage with an in-order store buffer of SB_DEPTH entries, so ST retires without waiting for ready_M.
- Loads hit in the buffer are forwarded in one cycle; load misses drain the buffer first, then issue to memory.
- Sits between the core pipeline (request side) and the shared data memory port (enable/addr/wr_data/rd_data/ready).

---
 rtl/core_lsu.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/core_lsu.sv
// -----------------------------------------------------------------------------
// core_lsu : load/store unit for the core's M stage.
//
// Stores are placed in an in-order store buffer and retire to memory in the
// background, so a store never waits for the memory port. Loads are either
// forwarded from the buffer (optional) or wait for the buffer to drain and
// then read the shared data memory.
//
// Optional feature macro: LSU_STORE_FWD_EN
//   defined   : a load that matches a buffered store returns the youngest
//               matching data one cycle after acceptance, no memory access.
//   undefined : every load drains the buffer and then reads memory; the
//               address compare logic is not built.
//
// Parameters
//   DATA_WIDTH  data width (default 8)
//   ADDR_WIDTH  address width (default 12)
//   SB_DEPTH    store-buffer entries, power of two, >= 2 (default 4)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/op/addr/wr_data, req_ready
//                       pipeline request (op 01 = LD, 10 = ST, else no-op)
//   ld_valid, ld_data   load result pulse / held load data
//   sb_empty, sb_count  buffer status
//   enable_M, addr_M, wr_data_M, rd_data_M, ready_M
//                       memory port (enable 01 = read, 10 = write, 00 = idle)
// -----------------------------------------------------------------------------
module core_lsu #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int SB_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [1:0]                    req_op,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wr_data,
    output logic                          req_ready,
    output logic                          ld_valid,
    output logic [DATA_WIDTH-1:0]         ld_data,
    output logic                          sb_empty,
    output logic [$clog2(SB_DEPTH):0]     sb_count,
    output logic [1:0]                    enable_M,
    output logic [ADDR_WIDTH-1:0]         addr_M,
    output logic [DATA_WIDTH-1:0]         wr_data_M,
    input  logic [DATA_WIDTH-1:0]         rd_data_M,
    input  logic                          ready_M
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(SB_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [1:0] OP_LD   = 2'b01;
    localparam logic [1:0] OP_ST   = 2'b10;
    localparam logic [1:0] EN_IDLE = 2'b00;
    localparam logic [1:0] EN_RD   = 2'b01;
    localparam logic [1:0] EN_WR   = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_DRAIN = 2'd1,
        LD_ISSUE = 2'd2,
        LD_RESP  = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  sb_addr_r [SB_DEPTH];
    logic [DATA_WIDTH-1:0]  sb_data_r [SB_DEPTH];
    logic [PW-1:0]          head_r, tail_r;
    logic [CW-1:0]          count_r;
    logic [ADDR_WIDTH-1:0]  ld_addr_r;
    logic [DATA_WIDTH-1:0]  ld_data_r;
    logic                   ld_valid_r;

    logic                   req_ready_s;
    logic [1:0]             enable_s;
    logic [ADDR_WIDTH-1:0]  addr_s;
    logic [DATA_WIDTH-1:0]  wdata_s;
    logic                   accept_s, st_acc_s, ld_acc_s, retire_s, drained_s;
    logic                   fwd_hit_s;
    logic [DATA_WIDTH-1:0]  fwd_data_s;

    assign accept_s = req_valid & req_ready_s;
    assign st_acc_s = accept_s & (req_op == OP_ST);
    assign ld_acc_s = accept_s & (req_op == OP_LD);
    assign retire_s = ready_M & (enable_s == EN_WR);
    // The buffer is (or becomes at this edge) empty with no write left over.
    assign drained_s = (count_r == CNT_ZERO) | ((count_r == CNT_ONE) & retire_s);

    // Port-side outputs: derived from the registered state and count only.
    always_comb begin
        req_ready_s = 1'b0;
        enable_s    = EN_IDLE;
        addr_s      = sb_addr_r[head_r];
        wdata_s     = sb_data_r[head_r];
        case (state_r)
            RUN: begin
                req_ready_s = (count_r != CNT_FULL);
                if (count_r != CNT_ZERO) begin
                    enable_s = EN_WR;
                end else begin
                    enable_s = EN_IDLE;
                end
            end
            LD_DRAIN: begin
                if (count_r != CNT_ZERO) begin
                    enable_s = EN_WR;
                end else begin
                    enable_s = EN_IDLE;
                end
            end
            LD_ISSUE: begin
                enable_s = EN_RD;
                addr_s   = ld_addr_r;
                wdata_s  = {DATA_WIDTH{1'b0}};
            end
            LD_RESP: begin
                enable_s = EN_IDLE;
            end
            default: begin
                enable_s = EN_IDLE;
            end
        endcase
    end

`ifdef LSU_STORE_FWD_EN
    logic [SB_DEPTH-1:0] fwd_match_s;

    // Per-slot match in age order (slot k = k-th oldest entry).
    always_comb begin
        fwd_match_s = {SB_DEPTH{1'b0}};
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_match_s[k] = (CW'(k) < count_r) &&
                             (sb_addr_r[head_r + PW'(k)] == req_addr);
        end
    end

    // Youngest match wins: later (younger) slots overwrite earlier ones.
    always_comb begin
        fwd_hit_s  = |fwd_match_s;
        fwd_data_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < SB_DEPTH; k++) begin
            fwd_data_s = fwd_match_s[k] ? sb_data_r[head_r + PW'(k)] : fwd_data_s;
        end
    end
`else
    assign fwd_hit_s  = 1'b0;
    assign fwd_data_s = {DATA_WIDTH{1'b0}};
`endif

    // Next-state logic of the load sequencing FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (ld_acc_s && !fwd_hit_s) begin
                    if (drained_s) begin
                        state_s = LD_ISSUE;
                    end else begin
                        state_s = LD_DRAIN;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            LD_DRAIN: begin
                if (drained_s) begin
                    state_s = LD_ISSUE;
                end else begin
                    state_s = LD_DRAIN;
                end
            end
            LD_ISSUE: begin
                if (ready_M) begin
                    state_s = LD_RESP;
                end else begin
                    state_s = LD_ISSUE;
                end
            end
            LD_RESP: begin
                state_s = RUN;
            end
            default: begin
                state_s = RUN;
            end
        endcase
    end

    // Control registers: FSM state, FIFO pointers/count, load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= RUN;
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= CNT_ZERO;
            ld_addr_r  <= {ADDR_WIDTH{1'b0}};
            ld_data_r  <= {DATA_WIDTH{1'b0}};
            ld_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ld_valid_r <= 1'b0;
            if (st_acc_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (retire_s) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({st_acc_s, retire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (ld_acc_s) begin
                ld_addr_r <= req_addr;
            end
            if (ld_acc_s && fwd_hit_s) begin
                ld_data_r  <= fwd_data_s;
                ld_valid_r <= 1'b1;
            end else if ((state_r == LD_ISSUE) && ready_M) begin
                ld_data_r  <= rd_data_M;
                ld_valid_r <= 1'b1;
            end
        end
    end

    // Buffer storage: an accepted store is written at the tail slot.
    always_ff @(posedge clk) begin
        if (st_acc_s) begin
            sb_addr_r[tail_r] <= req_addr;
            sb_data_r[tail_r] <= req_wr_data;
        end
    end

    assign req_ready = req_ready_s;
    assign enable_M  = enable_s;
    assign addr_M    = addr_s;
    assign wr_data_M = wdata_s;
    assign ld_valid  = ld_valid_r;
    assign ld_data   = ld_data_r;
    assign sb_count  = count_r;
    assign sb_empty  = (count_r == CNT_ZERO) & (enable_s != EN_WR);

endmodule
